// File: rtl/sseg_pkg.sv
// Shared types, constants and helpers for the scanned seven-segment display blocks.
package sseg_pkg;

    localparam int DIGITS   = 4;
    localparam int NIBBLE_W = 4;

    typedef logic [1:0] digit_idx_t;

    localparam logic [DIGITS-1:0] AN_OFF = 4'b1111;

    // Active-low one-hot anode pattern that lights only digit idx.
    function automatic logic [DIGITS-1:0] an_onehot(input digit_idx_t idx);
        return ~({{(DIGITS-1){1'b0}}, 1'b1} << idx);
    endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Refresh prescaler: emits a one-cycle SCAN_TICK every REFRESH_DIV clocks.
module sseg_tick_gen #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic CLK,
    input  logic RST,
    output logic SCAN_TICK
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (RST)
            cnt <= '0;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign SCAN_TICK = (cnt == CNT_LAST);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-aligned value commits.
// Optional leading-zero blanking is enabled by defining SSEG_LZ_BLANK_EN.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [DIGITS*NIBBLE_W-1:0]   DATA_IN,
    input  logic [DIGITS-1:0]            DP_IN,
    input  logic                         LOAD,
    output logic                         BUSY,
    output logic [NIBBLE_W-1:0]          HEX,
    output logic [DIGITS-1:0]            AN,
    output logic                         DP,
    output logic [1:0]                   DIGIT_SEL,
    output logic                         SCAN_TICK
);

    digit_idx_t                       idx;
    logic [DIGITS*NIBBLE_W-1:0]       pend_val;
    logic [DIGITS-1:0]                pend_dp;
    logic                             pend_flag;
    logic [DIGITS*NIBBLE_W-1:0]       disp_val;
    logic [DIGITS-1:0]                disp_dp;
    logic                             frame_end;
    logic                             blank;

    sseg_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick_gen (
        .CLK       (CLK),
        .RST       (RST),
        .SCAN_TICK (SCAN_TICK)
    );

    assign frame_end = SCAN_TICK && (idx == 2'd3);

    // A LOAD on the frame edge commits the older pending value and re-arms with the new one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx       <= '0;
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
            disp_val  <= '0;
            disp_dp   <= '0;
        end else begin
            if (SCAN_TICK)
                idx <= idx + 1'b1;
            if (frame_end && pend_flag) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            if (LOAD) begin
                pend_val  <= DATA_IN;
                pend_dp   <= DP_IN;
                pend_flag <= 1'b1;
            end else if (frame_end) begin
                pend_flag <= 1'b0;
            end
        end
    end

    // NOTE: blank gets its default before any conditional update so no latch is inferred.
    always_comb begin
        blank = 1'b0;
`ifdef SSEG_LZ_BLANK_EN
        blank = (idx != 2'd0) && ((disp_val >> (NIBBLE_W * int'(idx))) == '0);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            HEX       <= '0;
            AN        <= AN_OFF;
            DP        <= 1'b1;
            DIGIT_SEL <= '0;
        end else begin
            HEX       <= disp_val[NIBBLE_W*idx +: NIBBLE_W];
            AN        <= blank ? AN_OFF : an_onehot(idx);
            DP        <= blank | ~disp_dp[idx];
            DIGIT_SEL <= idx;
        end
    end

    assign BUSY = pend_flag;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl at REFRESH_DIV = 4 (one frame = 16 cycles).
module tb_sseg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        busy;
    logic [3:0]  hex;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        scan_tick;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int cyc           = 0;

    sseg_scan_ctrl #(
        .REFRESH_DIV (4)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .DATA_IN   (data_in),
        .DP_IN     (dp_in),
        .LOAD      (load),
        .BUSY      (busy),
        .HEX       (hex),
        .AN        (an),
        .DP        (dp),
        .DIGIT_SEL (digit_sel),
        .SCAN_TICK (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic goto_cyc(input int target);
        while (cyc < target) step();
    endtask

    function automatic logic blanked(input logic [15:0] v, input int d);
`ifdef SSEG_LZ_BLANK_EN
        if (d == 0) return 1'b0;
        return (v >> (4 * d)) == 16'h0;
`else
        return 1'b0;
`endif
    endfunction

    // Called right after a frame-boundary edge; checks the 16 cycles of the next frame.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] dpv);
        for (int k = 0; k < 16; k++) begin
            int d;
            logic [3:0] exp_an;
            logic       exp_dp;
            step();
            d      = k / 4;
            exp_an = blanked(v, d) ? 4'b1111 : ~(4'b0001 << d);
            exp_dp = blanked(v, d) ? 1'b1 : ~dpv[d];
            check($sformatf("frame_hex_d%0d", d), {12'h0, hex}, {12'h0, v[4*d +: 4]});
            check($sformatf("frame_an_d%0d", d),  {12'h0, an},  {12'h0, exp_an});
            check($sformatf("frame_dp_d%0d", d),  {15'h0, dp},  {15'h0, exp_dp});
            check($sformatf("frame_sel_d%0d", d), {14'h0, digit_sel}, 16'(d));
        end
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b1;
        data_in = 16'hFFFF;
        dp_in   = 4'hF;

        // Reset held for 3 cycles with LOAD asserted
        repeat (3) step();
        check("rst_an",   {12'h0, an},   16'h000F);
        check("rst_dp",   {15'h0, dp},   16'h0001);
        check("rst_busy", {15'h0, busy}, 16'h0000);
        check("rst_hex",  {12'h0, hex},  16'h0000);
        check("rst_sel",  {14'h0, digit_sel}, 16'h0000);
        check("rst_tick", {15'h0, scan_tick}, 16'h0000);
        rst  = 1'b0;
        load = 1'b0;
        cyc  = 0;

        step();
        check("rel_an",   {12'h0, an},   16'h000E);
        check("rel_hex",  {12'h0, hex},  16'h0000);
        check("rel_busy", {15'h0, busy}, 16'h0000);
        step();
        check("tick_c2",  {15'h0, scan_tick}, 16'h0000);
        step();
        check("tick_c3",  {15'h0, scan_tick}, 16'h0001);
        step();
        check("tick_c4",  {15'h0, scan_tick}, 16'h0000);

        // Scan order with 0x1234, decimal point on digit 2
        data_in = 16'h1234; dp_in = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        check("load_busy", {15'h0, busy}, 16'h0001);
        check("pre_sel",   {14'h0, digit_sel}, 16'h0001);
        check("pre_an",    {12'h0, an}, blanked(16'h0, 1) ? 16'h000F : 16'h000D);
        goto_cyc(15);
        check("busy_pre_bnd", {15'h0, busy}, 16'h0001);
        step();
        check("busy_post_bnd", {15'h0, busy}, 16'h0000);
        check("old_hex_c16",   {12'h0, hex},  16'h0000);
        check("old_sel_c16",   {14'h0, digit_sel}, 16'h0003);
        check_frame(16'h1234, 4'b0100);

        // Deferred commit: LOAD during digit 1 keeps the old frame running
        goto_cyc(37);
        data_in = 16'hABCD; dp_in = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        check("dfr_busy", {15'h0, busy}, 16'h0001);
        goto_cyc(41);
        check("dfr_hex_d2", {12'h0, hex}, 16'h0002);
        check("dfr_dp_d2",  {15'h0, dp},  16'h0000);
        goto_cyc(45);
        check("dfr_hex_d3", {12'h0, hex}, 16'h0001);
        check("dfr_an_d3",  {12'h0, an},  16'h0007);
        goto_cyc(47);
        check("dfr_busy_hold", {15'h0, busy}, 16'h0001);
        step();
        check("dfr_busy_fall", {15'h0, busy}, 16'h0000);
        check("dfr_hex_old",   {12'h0, hex},  16'h0001);
        check_frame(16'hABCD, 4'b0000);

        // Boundary collision: second LOAD lands on the frame edge
        step();
        data_in = 16'h1111; load = 1'b1;
        step();
        load = 1'b0;
        check("col_busy1", {15'h0, busy}, 16'h0001);
        goto_cyc(79);
        data_in = 16'h2222; load = 1'b1;
        step();
        load = 1'b0;
        check("col_busy_hold", {15'h0, busy}, 16'h0001);
        check_frame(16'h1111, 4'b0000);
        check("col_busy_fall", {15'h0, busy}, 16'h0000);
        check_frame(16'h2222, 4'b0000);

        // Last-wins: three back-to-back LOADs
        step();
        data_in = 16'h0001; load = 1'b1;
        step();
        data_in = 16'h0002;
        step();
        data_in = 16'h0003;
        step();
        load = 1'b0;
        check("lw_busy", {15'h0, busy}, 16'h0001);
        goto_cyc(128);
        check("lw_hex_old", {12'h0, hex}, 16'h0002);
        check_frame(16'h0003, 4'b0000);

`ifdef SSEG_LZ_BLANK_EN
        // Leading-zero blanking; DP_IN must not light blanked digits
        step();
        data_in = 16'h0050; dp_in = 4'b1111; load = 1'b1;
        step();
        load = 1'b0;
        goto_cyc(160);
        check_frame(16'h0050, 4'b1111);
        step();
        data_in = 16'h0000; load = 1'b1;
        step();
        load = 1'b0;
        goto_cyc(192);
        check_frame(16'h0000, 4'b1111);
`else
        // Without blanking, 0x0005 shows all four digits
        step();
        data_in = 16'h0005; dp_in = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        goto_cyc(160);
        check_frame(16'h0005, 4'b0000);
`endif

        // Reset mid-operation with a pending LOAD in flight
        step();
        data_in = 16'h9999; dp_in = 4'b1111; load = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("mrst_an",   {12'h0, an},   16'h000F);
        check("mrst_busy", {15'h0, busy}, 16'h0000);
        check("mrst_dp",   {15'h0, dp},   16'h0001);
        check("mrst_hex",  {12'h0, hex},  16'h0000);
        check("mrst_tick", {15'h0, scan_tick}, 16'h0000);
        rst  = 1'b0;
        load = 1'b0;
        cyc  = 0;
        step();
        check("mrel_an",   {12'h0, an},   16'h000E);
        check("mrel_hex",  {12'h0, hex},  16'h0000);
        check("mrel_busy", {15'h0, busy}, 16'h0000);
        goto_cyc(16);
        check_frame(16'h0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Four-digit seven-segment scan controller sitting directly upstream of the hex-to-segment decoder (`HEX_7seg`). It latches a 16-bit display value through a load handshake, divides `CLK` down to a per-digit refresh tick, and rotates through digits 0–3. For the active digit it presents the nibble, the active-low anode select and the active-low decimal point. Commits of new values are deferred to frame boundaries so a displayed frame never mixes old and new digits.

## Interface
- `REFRESH_DIV`, 50000: `CLK` cycles per digit slot; legal range 2 to 2^24−1.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `DATA_IN`  in  16  display value; digit i shows `DATA_IN[4i+3:4i]`; digit 3 is most significant.
- `DP_IN`  in  4  decimal-point enables, active-high, one per digit; sampled with `DATA_IN`.
- `LOAD`  in  1  single-cycle strobe that captures `DATA_IN`/`DP_IN` into the pending register.
- `BUSY`  out  1  high while a pending value awaits commit.
- `HEX`  out  4  nibble of the active digit; feeds the decoder.
- `AN`  out  4  anode selects, active-low, one-hot-low; `AN[i]` low means digit i is lit.
- `DP`  out  1  decimal point, active-low.
- `DIGIT_SEL`  out  2  index of the active digit.
- `SCAN_TICK`  out  1  one-cycle pulse marking each digit advance.

## Operation
- **Prescaler:** counts 0 to `REFRESH_DIV`−1, then wraps. `SCAN_TICK` is high in the cycle where the count equals `REFRESH_DIV`−1.
- **Digit index:** advances 0→1→2→3→0 on the edge that ends each `SCAN_TICK` cycle.
- **Frame boundary:** the edge where the index goes 3→0.
- **Load path:**
  - `LOAD` writes the pending register and sets the pending flag; `BUSY` equals the pending flag.
  - At a frame boundary with the flag set, pending is copied to the display register and the flag clears.
  - Back-to-back `LOAD`s: last one wins.
  - `LOAD` coinciding with a boundary edge: the previous pending value is committed, the new data is written to pending, and the flag stays set. The new data commits at the next boundary.
- **Output generation:** `HEX`, `AN`, `DP` and `DIGIT_SEL` are registered from the index and the display register. Exactly one `AN` bit is low at any time, except under blanking or reset.
- **Reset:**
  - Prescaler = 0, index = 0, display = 0, pending = 0, flag = 0.
  - `AN` = 4'b1111, `DP` = 1, `HEX` = 0, `DIGIT_SEL` = 0, `BUSY` = 0, `SCAN_TICK` = 0.
- **Reset mid-operation:** `RST` overrides everything, including a simultaneous `LOAD`, and discards the pending value.

## Timing
- **First cycle after reset release:** `AN` = 4'b1110 and `HEX` = display[3:0] = 0, i.e. one-cycle output latency from the index.
- **Digit outputs:** change one cycle after the index edge and hold for exactly `REFRESH_DIV` cycles.
- **Full frame:** 4×`REFRESH_DIV` cycles.
- **`BUSY`:** rises the cycle after `LOAD`. It falls the cycle after the boundary edge, or stays high in the coincident case.
- **Commit-to-display latency:** the new value is first visible on `HEX` one cycle after the boundary, on digit 0.
- **Worst-case `LOAD`-to-visible latency:** 4×`REFRESH_DIV`+1 cycles.

## Configuration
- **Macro:** `SSEG_LZ_BLANK_EN`, leading-zero blanking.
- **Defined:** a digit i ≥ 1 is blanked when display nibbles i through 3 are all zero. While blanked, `AN` = 4'b1111 and `DP` = 1 for that slot; `HEX` still shows the nibble. Digit 0 is never blanked. `DP_IN` does not override blanking.
- **Undefined:** all four digits are always lit. With `REFRESH_DIV` = 4, display 0x0005 shows "0005".

## Structure
- **Shared package `sseg_pkg`:**
  - `DIGITS` = 4 and `NIBBLE_W` = 4.
  - Digit-index typedef (2 bits).
  - Constant `AN_OFF` = 4'b1111.
  - One-hot-low anode lookup function (index → `AN` pattern).
- **Sub-module `sseg_tick_gen`:** holds the prescaler (`CLK`, `RST`, `REFRESH_DIV` → `SCAN_TICK`). It is reusable by other scanned displays.
- **Top level:** holds the index counter, the pending/display registers and the output registers.

## Test plan
- **Reset:** hold `RST` for 3 cycles with `LOAD`=1 → `AN`=1111, `DP`=1, `BUSY`=0. After release, `AN`=1110, `HEX`=0.
- **Scan order (`REFRESH_DIV`=4):**
  - Stimulus: `LOAD` 0x1234 with `DP_IN`=4'b0100.
  - Required: after the next boundary, `HEX` sequence 4,3,2,1 with `AN` 1110,1101,1011,0111, each held 4 cycles. `DP`=0 only on digit 2.
- **Deferred commit:** `LOAD` 0xABCD during digit 1 → `BUSY`=1. `HEX` stays on the old value until the 3→0 edge. `BUSY` falls the cycle after that edge and digit 0 shows D.
- **Boundary collision:** `LOAD` 0x1111, then `LOAD` 0x2222 on the boundary cycle → the frame shows 1111, `BUSY` stays 1, and the next frame shows 2222.
- **Last-wins:** `LOAD`s of 0x0001, 0x0002 and 0x0003 on consecutive cycles → only 0x0003 is ever displayed.
- **Blanking (`SSEG_LZ_BLANK_EN` defined):** `LOAD` 0x0050 → digits 3 and 2 have `AN`=1111, digit 1 shows 5, digit 0 shows 0. `LOAD` 0x0000 → only digit 0 is lit.
